// File: rtl/fp_adder_pipe.sv
// fp_adder_pipe: 3-stage pipelined floating-point adder (RNE, flush-to-zero) with valid/ready flow control.
// Define FP_ADDER_FLAGS_EN to add flags[3:0] = {invalid, overflow, underflow, inexact} aligned with result.
module fp_adder_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result
`ifdef FP_ADDER_FLAGS_EN
  ,
  output logic [3:0]           flags
`endif
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SIG = MAN_W + 1;
  localparam int EXT = MAN_W + 4;
  localparam int SUM = MAN_W + 5;
  localparam int EW  = EXP_W + 2;
  localparam int LZW = $clog2(SUM + 1);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EW-1:0]    E_MAX    = EW'((1 << EXP_W) - 1);
  localparam logic [31:0]      COLLAPSE = 32'(EXT - 1);

  logic v1, v2, v3;
  logic ready1, ready2, ready3;

  assign ready3    = !v3 || out_ready;
  assign ready2    = !v2 || ready3;
  assign ready1    = !v1 || ready2;
  assign in_ready  = ready1;
  assign out_valid = v3;

  // ---------------- S1: unpack, classify, order by magnitude ----------------
  logic                   sa, sb;
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       ma, mb;
  logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
  logic [EXP_W+MAN_W-1:0] mag_a, mag_b;
  logic [EXP_W-1:0]       ea_f, eb_f;
  logic [SIG-1:0]         sig_a, sig_b;
  logic                   spec_d;
  logic [W-1:0]           spec_res_d;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign a_nan  = (ea == EXP_ONES) && (ma != '0);
  assign b_nan  = (eb == EXP_ONES) && (mb != '0);
  assign a_inf  = (ea == EXP_ONES) && (ma == '0);
  assign b_inf  = (eb == EXP_ONES) && (mb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign mag_a  = a_zero ? '0 : {ea, ma};
  assign mag_b  = b_zero ? '0 : {eb, mb};
  assign a_big  = mag_a >= mag_b;
  assign ea_f   = a_zero ? '0 : ea;
  assign eb_f   = b_zero ? '0 : eb;
  assign sig_a  = a_zero ? '0 : {1'b1, ma};
  assign sig_b  = b_zero ? '0 : {1'b1, mb};

  always_comb begin
    spec_d     = 1'b1;
    spec_res_d = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) spec_res_d = QNAN;
    else if (a_inf) spec_res_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else if (b_inf) spec_res_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
    else spec_d = 1'b0;
  end

`ifdef FP_ADDER_FLAGS_EN
  logic inv_d;
  assign inv_d = (a_nan && !ma[MAN_W-1]) || (b_nan && !mb[MAN_W-1]) ||
                 (a_inf && b_inf && (sa != sb));
  logic s1_inv, s2_inv;
`endif

  logic             s1_sign, s1_sub, s1_spec;
  logic [EXP_W-1:0] s1_exp, s1_diff;
  logic [SIG-1:0]   s1_sigx, s1_sigy;
  logic [W-1:0]     s1_spec_res;

  // ---------------- S2: align the smaller operand, add or subtract ----------------
  logic [2*EXT-1:0] y_wide;
  logic [EXT-1:0]   y_al;
  logic [SUM-1:0]   x_al, sum_d;

  always_comb begin
    y_wide = {s1_sigy, 3'b000, {EXT{1'b0}}} >> s1_diff;
    if (32'(s1_diff) >= COLLAPSE) y_al = {{(EXT-1){1'b0}}, |s1_sigy};
    else y_al = {y_wide[2*EXT-1:EXT+1], y_wide[EXT] | (|y_wide[EXT-1:0])};
    x_al  = {1'b0, s1_sigx, 3'b000};
    sum_d = s1_sub ? (x_al - {1'b0, y_al}) : (x_al + {1'b0, y_al});
  end

  logic             s2_sign, s2_sub, s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [SUM-1:0]   s2_sum;
  logic [W-1:0]     s2_spec_res;

  // ---------------- S3: normalise, round to nearest even, pack ----------------
  logic [LZW-1:0] lzc;
  logic [EXT-1:0] nm;
  logic [EW-1:0]  e_base, e_norm, e_rnd;
  logic [SIG:0]   mant_rnd;
  logic [MAN_W-1:0] man_out;
  logic           round_up, res_zero, ovf, unf;
  logic [W-1:0]   res_d;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < EXT; i++)
      if (s2_sum[i]) lzc = LZW'(EXT - 1 - i);
    e_base = {2'b00, s2_exp};
    if (s2_sum[SUM-1]) begin
      nm     = {s2_sum[SUM-1:2], s2_sum[1] | s2_sum[0]};
      e_norm = e_base + EW'(1);
    end else begin
      nm     = s2_sum[EXT-1:0] << lzc;
      e_norm = e_base - {{(EW-LZW){1'b0}}, lzc};
    end
    round_up = nm[2] && (nm[3] || nm[1] || nm[0]);
    mant_rnd = {1'b0, nm[EXT-1:3]} + {{SIG{1'b0}}, round_up};
    // Rounding carry leaves 10..0, so dropping the LSB renormalises it.
    e_rnd    = mant_rnd[SIG] ? (e_norm + EW'(1)) : e_norm;
    man_out  = mant_rnd[SIG] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
    res_zero = (s2_sum == '0);
    ovf      = !e_rnd[EW-1] && (e_rnd >= E_MAX);
    unf      = e_rnd[EW-1] || (e_rnd == '0);

    if (s2_spec)       res_d = s2_spec_res;
    else if (res_zero) res_d = {s2_sign && !s2_sub, {(W-1){1'b0}}};
    else if (ovf)      res_d = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
    else if (unf)      res_d = {s2_sign, {(W-1){1'b0}}};
    else               res_d = {s2_sign, e_rnd[EXP_W-1:0], man_out};
  end

`ifdef FP_ADDER_FLAGS_EN
  logic [3:0] flags_d;
  logic       fin;
  always_comb begin
    fin     = !s2_spec && !res_zero;
    flags_d = {s2_spec && s2_inv,
               fin && ovf,
               fin && !ovf && unf,
               fin && ((nm[2:0] != '0) || ovf || unf)};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      v3          <= 1'b0;
      s1_sign     <= 1'b0;
      s1_sub      <= 1'b0;
      s1_spec     <= 1'b0;
      s1_exp      <= '0;
      s1_diff     <= '0;
      s1_sigx     <= '0;
      s1_sigy     <= '0;
      s1_spec_res <= '0;
      s2_sign     <= 1'b0;
      s2_sub      <= 1'b0;
      s2_spec     <= 1'b0;
      s2_exp      <= '0;
      s2_sum      <= '0;
      s2_spec_res <= '0;
      result      <= '0;
`ifdef FP_ADDER_FLAGS_EN
      s1_inv      <= 1'b0;
      s2_inv      <= 1'b0;
      flags       <= '0;
`endif
    end else begin
      if (ready1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_sign     <= a_big ? sa : sb;
          s1_sub      <= sa ^ sb;
          s1_spec     <= spec_d;
          s1_spec_res <= spec_res_d;
          s1_exp      <= a_big ? ea_f : eb_f;
          s1_diff     <= a_big ? (ea_f - eb_f) : (eb_f - ea_f);
          s1_sigx     <= a_big ? sig_a : sig_b;
          s1_sigy     <= a_big ? sig_b : sig_a;
`ifdef FP_ADDER_FLAGS_EN
          s1_inv      <= inv_d;
`endif
        end
      end
      if (ready2) begin
        v2 <= v1;
        if (v1) begin
          s2_sign     <= s1_sign;
          s2_sub      <= s1_sub;
          s2_spec     <= s1_spec;
          s2_spec_res <= s1_spec_res;
          s2_exp      <= s1_exp;
          s2_sum      <= sum_d;
`ifdef FP_ADDER_FLAGS_EN
          s2_inv      <= s1_inv;
`endif
        end
      end
      if (ready3) begin
        v3 <= v2;
        if (v2) begin
          result <= res_d;
`ifdef FP_ADDER_FLAGS_EN
          flags  <= flags_d;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_adder_pipe.sv
// tb_fp_adder_pipe: directed self-checking bench for fp_adder_pipe (binary16 and binary32 instances).
// Flag checks are included when FP_ADDER_FLAGS_EN is defined.
module tb_fp_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_ready;
  logic        in_valid_h, in_ready_h, out_valid_h;
  logic [15:0] a_h, b_h, result_h;
  logic        in_valid_s, in_ready_s, out_valid_s;
  logic [31:0] a_s, b_s, result_s;
`ifdef FP_ADDER_FLAGS_EN
  logic [3:0]  flags_h, flags_s;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_adder_pipe dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .a(a_h), .b(b_h), .out_valid(out_valid_h), .out_ready(out_ready), .result(result_h)
`ifdef FP_ADDER_FLAGS_EN
    , .flags(flags_h)
`endif
  );

  fp_adder_pipe #(.EXP_W(8), .MAN_W(23)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .a(a_s), .b(b_s), .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s)
`ifdef FP_ADDER_FLAGS_EN
    , .flags(flags_s)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drives one operand pair at a falling edge; it is captured at the following rising edge.
  task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b, input bit wide);
    if (wide) begin a_s = op_a; b_s = op_b; in_valid_s = 1'b1; end
    else begin a_h = op_a[15:0]; b_h = op_b[15:0]; in_valid_h = 1'b1; end
    @(negedge clk);
    in_valid_h = 1'b0;
    in_valid_s = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                       input logic [31:0] expected, input bit wide);
    applyStimulus(op_a, op_b, wide);
    @(negedge clk);
    checkOutput({tag, "_early"}, 32'(wide ? out_valid_s : out_valid_h), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(wide ? out_valid_s : out_valid_h), 32'd1);
    checkOutput(tag, wide ? result_s : {16'h0, result_h}, expected);
    @(negedge clk);
  endtask

  logic [15:0] stream_a   [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                  16'h4500, 16'h4600, 16'h4700, 16'h4800};
  logic [15:0] stream_exp [8] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500,
                                  16'h4600, 16'h4700, 16'h4800, 16'h4880};

  initial begin
    int sent, recvd, cyc;
    bit saw_full, held, extra;
    logic [15:0] held_val;

    rst_n = 1'b0; out_ready = 1'b1;
    in_valid_h = 1'b0; a_h = '0; b_h = '0;
    in_valid_s = 1'b0; a_s = '0; b_s = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid_h), 32'd0);
    checkOutput("reset_result", {16'h0, result_h}, 32'h0);
    checkOutput("reset_in_ready", 32'(in_ready_h), 32'd1);
    checkOutput("reset_out_valid_s", 32'(out_valid_s), 32'd0);

    $display("[TB] basic add/sub and latency");
    runOp("add_3p5_2p5", 32'h4300, 32'h4100, 32'h4600, 1'b0);
    runOp("sub_m3p5_2p5", 32'hC300, 32'h4100, 32'hBC00, 1'b0);

    $display("[TB] rounding");
    runOp("rnd_tie_even", 32'h3C00, 32'h1000, 32'h3C00, 1'b0);
    runOp("rnd_tie_up", 32'h3C01, 32'h1000, 32'h3C02, 1'b0);
    runOp("rnd_above_half", 32'h3C00, 32'h1001, 32'h3C01, 1'b0);

    $display("[TB] specials");
    runOp("inf_minus_inf", 32'h7C00, 32'hFC00, 32'h7E00, 1'b0);
    runOp("inf_plus_one", 32'h7C00, 32'h3C00, 32'h7C00, 1'b0);
    runOp("nan_in", 32'h7E01, 32'h3C00, 32'h7E00, 1'b0);
    runOp("overflow", 32'h7BFF, 32'h7BFF, 32'h7C00, 1'b0);
    runOp("cancel", 32'h3C00, 32'hBC00, 32'h0000, 1'b0);
    runOp("neg_zeros", 32'h8000, 32'h8000, 32'h8000, 1'b0);

    $display("[TB] streaming with backpressure");
    sent = 0; recvd = 0; cyc = 0; saw_full = 0; held = 0; held_val = '0;
    while (recvd < 8 && cyc < 60) begin
      out_ready  = ((cyc % 4) == 1 || (cyc % 4) == 2) ? 1'b0 : 1'b1;
      in_valid_h = (sent < 8);
      if (sent < 8) begin a_h = stream_a[sent]; b_h = 16'h3C00; end
      #1;
      if (held) checkOutput("stream_hold", {16'h0, result_h}, {16'h0, held_val});
      if (out_valid_h) checkOutput("stream_data", {16'h0, result_h}, {16'h0, stream_exp[recvd]});
      if (!in_ready_h) saw_full = 1'b1;
      held     = out_valid_h && !out_ready;
      held_val = result_h;
      if (out_valid_h && out_ready) recvd++;
      if (in_valid_h && in_ready_h) sent++;
      @(negedge clk);
      cyc++;
    end
    in_valid_h = 1'b0;
    out_ready  = 1'b1;
    checkOutput("stream_count", 32'(recvd), 32'd8);
    checkOutput("stream_full_stall", 32'(saw_full), 32'd1);
    extra = 1'b0;
    repeat (5) begin
      #1;
      if (out_valid_h) extra = 1'b1;
      @(negedge clk);
    end
    checkOutput("stream_no_dup", 32'(extra), 32'd0);

    $display("[TB] reset mid-flight");
    out_ready  = 1'b0;
    in_valid_h = 1'b1; a_h = 16'h4300; b_h = 16'h4100;
    @(negedge clk);
    a_h = 16'h3C00; b_h = 16'h3C00;
    @(negedge clk);
    in_valid_h = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_valid", 32'(out_valid_h), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(out_valid_h), 32'd0);
    checkOutput("rst_async_result", {16'h0, result_h}, 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    extra = 1'b0;
    repeat (6) begin
      if (out_valid_h) extra = 1'b1;
      @(negedge clk);
    end
    checkOutput("rst_no_stale", 32'(extra), 32'd0);
    runOp("rst_after_op", 32'hC300, 32'h4100, 32'hBC00, 1'b0);

    $display("[TB] binary32 instance");
    runOp("f32_add", 32'h40600000, 32'h40200000, 32'h40C00000, 1'b1);
`ifdef FP_ADDER_FLAGS_EN
    checkOutput("f32_add_flags", {28'h0, flags_s}, 32'h0);
`endif
    applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("f32_ovf_valid", 32'(out_valid_s), 32'd1);
    checkOutput("f32_ovf", result_s, 32'h7F800000);
`ifdef FP_ADDER_FLAGS_EN
    checkOutput("f32_ovf_flags", {28'h0, flags_s}, 32'h5);
`endif
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_adder_pipe.md
Name: fp_adder_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point adder. It generalises the combinational float16 adder to any exponent/mantissa width and adds a 3-stage pipeline with valid/ready flow control. Handles specials and uses round-to-nearest-even. Feeds the accumulation stage of the dot-product datapath; default parameters give binary16.

Parameters:
EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 10, stored mantissa field width (hidden bit implicit)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair a/b valid
in_ready  output  1  adder can accept the operand pair this cycle
a  input  1+EXP_W+MAN_W  operand A {sign, exp, man}
b  input  1+EXP_W+MAN_W  operand B
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
result  output  1+EXP_W+MAN_W  a+b, rounded

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid bits clear. out_valid=0, result=0, in_ready=1 once rst_n is high. Reset mid-operation discards all in-flight data.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Pipeline: S1 unpack/compare/swap, S2 align+add/sub, S3 normalise/round/pack. Each stage register has a valid bit.
- Stall rule: stage k advances when its downstream register is empty or advancing. in_ready = !v1 || (S1 advancing), combinational from stage state and out_ready.
- Latency: 3 cycles with no stall; sustained throughput 1/cycle with out_ready=1.
- Backpressure: while out_ready=0 and out_valid=1, result is held stable and nothing is lost. With all 3 stages full, in_ready=0.
- S1:
  - Subnormal inputs (exp=0) flush to signed zero.
  - Larger magnitude becomes operand X; X sign is the result sign for unlike-sign sums.
- S2:
  - Shift smaller significand right by exponent difference into guard/round/sticky bits.
  - Differences >= MAN_W+3 collapse to sticky only.
  - Add or subtract significands in MAN_W+4 bits.
- S3:
  - Leading-zero normalise; carry-out right-shifts by 1 and increments the exponent.
  - Round to nearest, ties to even. Mantissa overflow from rounding renormalises.
  - Exponent >= 2^EXP_W-1 yields signed infinity.
  - Underflow (exponent <= 0) yields signed zero (flush-to-zero).
  - Exact cancellation gives +0. (-0)+(-0) gives -0.
- Specials, decided in S1 and carried as a bypass:
  - Any NaN input gives canonical qNaN {0, all-ones exp, MSB mantissa=1}.
  - +inf + -inf gives canonical qNaN.
  - inf + finite gives that inf.
  - inf + same-sign inf gives inf.

Optional Feature:
FP_ADDER_FLAGS_EN:
- Defined: adds output port flags[3:0] = {invalid, overflow, underflow, inexact}. Flags are aligned and held with result, reset to 0, and valid only with out_valid.
  - invalid = NaN output from inf-inf or an sNaN input.
  - overflow = rounded to inf from finite operands.
  - underflow = flushed non-zero result.
  - inexact = any nonzero guard/round/sticky bit, or overflow/underflow.
- Undefined: no flags port and no flag logic.

Test Plan:
- Defaults, out_ready=1: a=0x4300 (3.5), b=0x4100 (2.5) -> result 0x4600 (6.0) exactly 3 cycles after in_valid. Then a=0xC300, b=0x4100 -> 0xBC00 (-1.0).
- Streaming: 8 back-to-back pairs with out_ready toggling 1,0,0,1 pattern -> in_ready drops once all 3 stages are full; all 8 results in order, none duplicated or lost; result stable while stalled.
- Rounding: 0x3C00+0x1000 (1.0+2^-11 tie) -> 0x3C00. 0x3C01+0x1000 -> 0x3C02. 0x3C00+0x1001 -> 0x3C01.
- Specials: 0x7C00+0xFC00 -> 0x7E00. 0x7C00+0x3C00 -> 0x7C00. 0x7E01+0x3C00 -> 0x7E00. 0x7BFF+0x7BFF -> 0x7C00. 0x3C00+0xBC00 -> 0x0000. 0x8000+0x8000 -> 0x8000.
- Reset mid-flight: 2 operations in flight, pulse rst_n low for 1 cycle asynchronously between edges -> out_valid=0 immediately, no stale result emerges afterward, and the next operation completes normally.
- Parametrised build: EXP_W=8, MAN_W=23. 0x40600000 (3.5) + 0x40200000 (2.5) -> 0x40C00000. With FP_ADDER_FLAGS_EN: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000, flags=4'b0101.
